// File: rtl/display_share_arbiter.sv
// rtl/display_share_arbiter.sv - two-requester frame-granular arbiter for a shared 4-digit multiplexed display
module display_share_arbiter #(
  parameter int DWELL_FRAMES = 4,
  parameter int LZ_BLANK     = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scan_tick,
  input  logic        req0,
  input  logic        req1,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
  output logic [1:0]  gnt,
  output logic [3:0]  AN,
  output logic [3:0]  small_bin,
  output logic        blank,
  output logic        frame_done
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  localparam logic [7:0] DWELL_MAX = 8'(DWELL_FRAMES);

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  digit_idx;
  logic [7:0]  dwell;
  logic [7:0]  dwell_sat;
  logic [15:0] snapshot;
  logic        last_served;
  logic        owned;
  logic        boundary;

  assign owned    = (state != IDLE);
  // Grants are only re-evaluated once a full scan frame has been shown,
  // so a requester never sees a partially drawn frame.
  assign boundary = scan_tick && (!owned || (digit_idx == 2'd3));

  // Frames completed by the current owner including the one ending now.
  assign dwell_sat = (dwell >= DWELL_MAX) ? DWELL_MAX : dwell + 8'd1;

  // Next-state decision, evaluated only at frame boundaries
  always_comb begin
    state_nxt = state;
    if (boundary) begin
      case (state)
        IDLE: begin
          if (req0 && req1)  state_nxt = last_served ? OWN0 : OWN1;
          else if (req0)     state_nxt = OWN0;
          else if (req1)     state_nxt = OWN1;
          else               state_nxt = IDLE;
        end
        OWN0: begin
          if (!req0)                               state_nxt = req1 ? OWN1 : IDLE;
          else if (req1 && (dwell_sat == DWELL_MAX)) state_nxt = OWN1;
          else                                     state_nxt = OWN0;
        end
        OWN1: begin
          if (!req1)                               state_nxt = req0 ? OWN0 : IDLE;
          else if (req0 && (dwell_sat == DWELL_MAX)) state_nxt = OWN0;
          else                                     state_nxt = OWN1;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Digit scan position: advances on every tick while owned, parked at 0 when idle
  always_ff @(posedge clk) begin
    if (reset || !owned)  digit_idx <= 2'd0;
    else if (scan_tick)   digit_idx <= digit_idx + 2'd1;
  end

  // Dwell counter: restarts on any new ownership, counts frames of a continuing owner
  always_ff @(posedge clk) begin
    if (reset) begin
      dwell <= 8'd0;
    end else if (boundary) begin
      if (!owned || (state_nxt != state)) dwell <= 8'd0;
      else                                dwell <= dwell_sat;
    end
  end

  // Snapshot and fairness pointer update whenever a frame is handed to an owner
  always_ff @(posedge clk) begin
    if (reset) begin
      snapshot    <= 16'h0000;
      last_served <= 1'b1;
    end else if (boundary) begin
      if (state_nxt == OWN0) begin
        snapshot    <= data0;
        last_served <= 1'b0;
      end else if (state_nxt == OWN1) begin
        snapshot    <= data1;
        last_served <= 1'b1;
      end
    end
  end

  // Frame completion pulse, one clock after an owned frame ends
  always_ff @(posedge clk) begin
    if (reset) frame_done <= 1'b0;
    else       frame_done <= boundary && owned;
  end

  assign gnt = {state == OWN1, state == OWN0};

  // Active-low one-cold digit enable
  always_comb begin
    AN = 4'b1111;
    if (owned) begin
      case (digit_idx)
        2'd0:    AN = 4'b1110;
        2'd1:    AN = 4'b1101;
        2'd2:    AN = 4'b1011;
        default: AN = 4'b0111;
      endcase
    end
  end

  // Nibble of the frozen snapshot for the digit currently enabled
  always_comb begin
    small_bin = snapshot[3:0];
    case (digit_idx)
      2'd0:    small_bin = snapshot[3:0];
      2'd1:    small_bin = snapshot[7:4];
      2'd2:    small_bin = snapshot[11:8];
      default: small_bin = snapshot[15:12];
    endcase
  end

  // Blanking: whole display off when idle, optional leading-zero suppression when owned
  always_comb begin
    blank = 1'b1;
    if (owned) begin
      blank = 1'b0;
      if (LZ_BLANK != 0) begin
        case (digit_idx)
          2'd1:    blank = (snapshot[15:4]  == 12'h000);
          2'd2:    blank = (snapshot[15:8]  == 8'h00);
          2'd3:    blank = (snapshot[15:12] == 4'h0);
          default: blank = 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_display_share_arbiter.sv
// tb/tb_display_share_arbiter.sv - self-checking bench for display_share_arbiter
module tb_display_share_arbiter;
  localparam int DWELL = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        scan_tick = 1'b0;
  logic        req0 = 1'b0;
  logic        req1 = 1'b0;
  logic [15:0] data0 = 16'h0000;
  logic [15:0] data1 = 16'h0000;
  logic [1:0]  gnt, gnt_b;
  logic [3:0]  AN, AN_b, small_bin, small_bin_b;
  logic        blank, blank_b, frame_done, frame_done_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  display_share_arbiter #(.DWELL_FRAMES(DWELL), .LZ_BLANK(1)) u_dut (
    .clk(clk), .reset(reset), .scan_tick(scan_tick), .req0(req0), .req1(req1),
    .data0(data0), .data1(data1), .gnt(gnt), .AN(AN), .small_bin(small_bin),
    .blank(blank), .frame_done(frame_done)
  );

  display_share_arbiter #(.DWELL_FRAMES(DWELL), .LZ_BLANK(0)) u_dut_nolz (
    .clk(clk), .reset(reset), .scan_tick(scan_tick), .req0(req0), .req1(req1),
    .data0(data0), .data1(data1), .gnt(gnt_b), .AN(AN_b), .small_bin(small_bin_b),
    .blank(blank_b), .frame_done(frame_done_b)
  );

  // Reference model: owner (-1 idle), digit position, frames held, last served, shown word
  int          m_owner = -1;
  int          m_pos = 0;
  int          m_frames = 0;
  int          m_last = 1;
  logic [15:0] m_word = 16'h0000;
  bit          m_fd = 1'b0;

  task automatic model_update();
    int nxt;
    int y;
    bit bnd;
    bit r[2];
    if (reset) begin
      m_owner = -1; m_pos = 0; m_frames = 0; m_last = 1; m_word = 16'h0000; m_fd = 1'b0;
      return;
    end
    m_fd = 1'b0;
    bnd  = 1'b0;
    if (scan_tick) begin
      if (m_owner < 0)      bnd = 1'b1;
      else if (m_pos == 3) begin bnd = 1'b1; m_fd = 1'b1; end
      else                  m_pos = m_pos + 1;
    end
    if (!bnd) return;
    r[0] = req0;
    r[1] = req1;
    if (m_owner < 0) begin
      if (r[0] && r[1]) nxt = 1 - m_last;
      else if (r[0])    nxt = 0;
      else if (r[1])    nxt = 1;
      else              nxt = -1;
    end else begin
      y = 1 - m_owner;
      if (!r[m_owner])                         nxt = r[y] ? y : -1;
      else if (r[y] && (m_frames + 1 >= DWELL)) nxt = y;
      else                                     nxt = m_owner;
    end
    if (m_owner >= 0 && nxt == m_owner) m_frames = m_frames + 1;
    else                                m_frames = 0;
    m_pos   = 0;
    m_owner = nxt;
    if (nxt >= 0) begin
      m_word = (nxt == 1) ? data1 : data0;
      m_last = nxt;
    end
  endtask

  function automatic logic [11:0] exp_outs();
    logic [1:0]  g;
    logic [3:0]  an;
    logic        bl;
    logic [15:0] upper;
    upper = m_word >> (4 * m_pos);
    if (m_owner < 0) begin
      g = 2'b00; an = 4'hF; bl = 1'b1;
    end else begin
      g  = (m_owner == 1) ? 2'b10 : 2'b01;
      an = 4'hF;
      an[m_pos] = 1'b0;
      bl = (m_pos != 0) && (upper == 16'h0000);
    end
    return {g, an, upper[3:0], bl, m_fd};
  endfunction

  task automatic cycle(input bit rst, input bit tick);
    @(negedge clk);
    reset = rst;
    scan_tick = tick;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    req0 = 1'b0;
    req1 = 1'b0;
    cycle(1'b1, 1'b0);
  endtask

  task automatic test_reset();
    req0 = 1'b1; req1 = 1'b1; data0 = 16'h5A5A; data1 = 16'hA5A5;
    cycle(1'b1, 1'b1);
    total++;
    if ({gnt, AN, small_bin, blank, frame_done} !== {2'b00, 4'hF, 4'h0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL reset_values got=%h exp=%h", {gnt, AN, small_bin, blank, frame_done}, {2'b00, 4'hF, 4'h0, 1'b1, 1'b0});
    end
    total++;
    if ({gnt_b, AN_b, blank_b, frame_done_b} !== {2'b00, 4'hF, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL reset_values_nolz got=%h exp=%h", {gnt_b, AN_b, blank_b, frame_done_b}, {2'b00, 4'hF, 1'b1, 1'b0});
    end
  endtask

  task automatic test_scan_frame();
    logic [3:0] an_tab[4];
    logic [3:0] nib_tab[4];
    an_tab  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    nib_tab = '{4'h4, 4'h3, 4'h2, 4'h1};
    do_reset();
    req0 = 1'b1; req1 = 1'b0; data0 = 16'h1234; data1 = 16'hFFFF;
    cycle(1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) cycle(1'b0, 1'b1);
      total++;
      if ({gnt, AN, small_bin, frame_done} !== {2'b01, an_tab[k], nib_tab[k], 1'b0}) begin
        bad++;
        $display("FAIL scan_digit%0d got=%h exp=%h", k, {gnt, AN, small_bin, frame_done}, {2'b01, an_tab[k], nib_tab[k], 1'b0});
      end
      cycle(1'b0, 1'b0);
    end
    cycle(1'b0, 1'b1);
    total++;
    if ({frame_done, gnt, AN} !== {1'b1, 2'b01, 4'b1110}) begin
      bad++;
      $display("FAIL scan_frame_done got=%h exp=%h", {frame_done, gnt, AN}, {1'b1, 2'b01, 4'b1110});
    end
    cycle(1'b0, 1'b0);
    total++;
    if (frame_done !== 1'b0) begin
      bad++;
      $display("FAIL scan_frame_done_width got=%b exp=0", frame_done);
    end
  endtask

  task automatic test_tie_dwell();
    logic [5:0] exp;
    do_reset();
    req0 = 1'b1; req1 = 1'b1; data0 = 16'h1111; data1 = 16'h2222;
    cycle(1'b0, 1'b1);
    total++;
    if (gnt !== 2'b01) begin
      bad++;
      $display("FAIL tie_first_grant got=%b exp=01", gnt);
    end
    for (int b = 1; b <= 8; b++) begin
      repeat (4) cycle(1'b0, 1'b1);
      exp = (b >= 4 && b < 8) ? {2'b10, 4'h2} : {2'b01, 4'h1};
      total++;
      if ({gnt, small_bin} !== exp) begin
        bad++;
        $display("FAIL dwell_boundary%0d got=%h exp=%h", b, {gnt, small_bin}, exp);
      end
    end
  endtask

  task automatic test_no_tearing();
    do_reset();
    req0 = 1'b1; req1 = 1'b0; data0 = 16'h00AB;
    cycle(1'b0, 1'b1);
    total++;
    if ({small_bin, blank} !== {4'hB, 1'b0}) begin bad++; $display("FAIL tear_d0 got=%h exp=%h", {small_bin, blank}, {4'hB, 1'b0}); end
    cycle(1'b0, 1'b1);
    data0 = 16'h00CD;
    cycle(1'b0, 1'b0);
    total++;
    if ({small_bin, blank} !== {4'hA, 1'b0}) begin bad++; $display("FAIL tear_d1 got=%h exp=%h", {small_bin, blank}, {4'hA, 1'b0}); end
    cycle(1'b0, 1'b1);
    total++;
    if ({small_bin, blank} !== {4'h0, 1'b1}) begin bad++; $display("FAIL tear_d2_blank got=%h exp=%h", {small_bin, blank}, {4'h0, 1'b1}); end
    cycle(1'b0, 1'b1);
    total++;
    if ({small_bin, blank} !== {4'h0, 1'b1}) begin bad++; $display("FAIL tear_d3_blank got=%h exp=%h", {small_bin, blank}, {4'h0, 1'b1}); end
    cycle(1'b0, 1'b1);
    total++;
    if ({small_bin, blank} !== {4'hD, 1'b0}) begin bad++; $display("FAIL tear_new_frame got=%h exp=%h", {small_bin, blank}, {4'hD, 1'b0}); end
  endtask

  task automatic test_release();
    do_reset();
    req0 = 1'b1; req1 = 1'b0; data0 = 16'h5678;
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    req0 = 1'b0;
    cycle(1'b0, 1'b0);
    total++;
    if (gnt !== 2'b01) begin bad++; $display("FAIL release_midframe got=%b exp=01", gnt); end
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    total++;
    if ({gnt, AN, blank, frame_done} !== {2'b00, 4'hF, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL release_idle got=%h exp=%h", {gnt, AN, blank, frame_done}, {2'b00, 4'hF, 1'b1, 1'b1});
    end
    req1 = 1'b1; data1 = 16'h9ABC;
    cycle(1'b0, 1'b0);
    total++;
    if (gnt !== 2'b00) begin bad++; $display("FAIL release_wait_tick got=%b exp=00", gnt); end
    cycle(1'b0, 1'b1);
    total++;
    if ({gnt, AN, small_bin} !== {2'b10, 4'b1110, 4'hC}) begin
      bad++;
      $display("FAIL release_own1 got=%h exp=%h", {gnt, AN, small_bin}, {2'b10, 4'b1110, 4'hC});
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req0 = 1'b0; req1 = 1'b1; data1 = 16'hBEEF;
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    total++;
    if ({gnt, AN} !== {2'b10, 4'b1011}) begin bad++; $display("FAIL rstmid_setup got=%h exp=%h", {gnt, AN}, {2'b10, 4'b1011}); end
    cycle(1'b1, 1'b1);
    total++;
    if ({gnt, AN, small_bin, blank, frame_done} !== {2'b00, 4'hF, 4'h0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL rstmid_digit2 got=%h exp=%h", {gnt, AN, small_bin, blank, frame_done}, {2'b00, 4'hF, 4'h0, 1'b1, 1'b0});
    end
    cycle(1'b0, 1'b1);
    repeat (3) cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b1);
    total++;
    if ({gnt, AN, small_bin, blank, frame_done} !== {2'b00, 4'hF, 4'h0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL rstmid_boundary got=%h exp=%h", {gnt, AN, small_bin, blank, frame_done}, {2'b00, 4'hF, 4'h0, 1'b1, 1'b0});
    end
  endtask

  task automatic test_zero_data();
    do_reset();
    req0 = 1'b1; req1 = 1'b0; data0 = 16'h0000;
    cycle(1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) cycle(1'b0, 1'b1);
      total++;
      if ({small_bin, blank, blank_b} !== {4'h0, (k != 0), 1'b0}) begin
        bad++;
        $display("FAIL zero_digit%0d got=%h exp=%h", k, {small_bin, blank, blank_b}, {4'h0, (k != 0), 1'b0});
      end
    end
  endtask

  task automatic test_random();
    logic [11:0] e;
    logic [11:0] e2;
    bit rst;
    bit tick;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) req0 = ~req0;
      if ($urandom_range(0, 15) == 0) req1 = ~req1;
      data0 = 16'($urandom) >> (4 * $urandom_range(0, 4));
      data1 = 16'($urandom) >> (4 * $urandom_range(0, 4));
      rst  = ($urandom_range(0, 499) == 0);
      tick = ($urandom_range(0, 2) == 0);
      cycle(rst, tick);
      e  = exp_outs();
      e2 = e;
      e2[1] = (m_owner < 0);
      total++;
      if ({gnt, AN, small_bin, blank, frame_done} !== e) begin
        bad++;
        $display("FAIL random_lz cyc=%0d got=%h exp=%h", i, {gnt, AN, small_bin, blank, frame_done}, e);
      end
      total++;
      if ({gnt_b, AN_b, small_bin_b, blank_b, frame_done_b} !== e2) begin
        bad++;
        $display("FAIL random_nolz cyc=%0d got=%h exp=%h", i, {gnt_b, AN_b, small_bin_b, blank_b, frame_done_b}, e2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan_frame();
    test_tie_dwell();
    test_no_tearing();
    test_release();
    test_reset_mid();
    test_zero_data();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/display_share_arbiter.md
DISPLAY_SHARE_ARBITER -- requirements
Module: display_share_arbiter

Interface
REQ-001 Parameter DWELL_FRAMES, default 4, meaning minimum complete scan frames a granted requester keeps the display once another requester waits; legal range 1..255.
REQ-002 Parameter LZ_BLANK, default 1, meaning 1 = leading-zero digits blanked, 0 = all four digits shown.
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 scan_tick  input  1  one-clk-wide digit-advance enable from the kHz divider, synchronous to clk.
REQ-006 req0, req1  input  1 each  display requests; level, held while display wanted.
REQ-007 data0, data1  input  16 each  4-nibble binary value of each requester.
REQ-008 gnt  output  2  one-hot grant (bit0 = requester 0); 2'b00 when idle.
REQ-009 AN  output  4  active-low digit enables, one-cold while owned.
REQ-010 small_bin  output  4  nibble for the enabled digit, fed to binary-to-segment decoder.
REQ-011 blank  output  1  1 = segment outputs suppressed for the current digit.
REQ-012 frame_done  output  1  one-clk pulse at completion of each owned scan frame.

Function
REQ-013 States SHALL be IDLE, OWN0, OWN1; gnt = 00/01/10 respectively, decoded from state register.
REQ-014 Frame boundary SHALL be defined as: scan_tick=1 with digit_idx=3 in OWN0/OWN1, or scan_tick=1 in IDLE.
REQ-015 State, grant, dwell counter and snapshot SHALL change only on a frame-boundary edge (except reset).
REQ-016 digit_idx (2 bits) SHALL increment on every scan_tick while owned, wrap 3->0, and hold 0 in IDLE.
REQ-017 AN SHALL be 4'b1111 in IDLE; while owned AN = 1110, 1101, 1011, 0111 for digit_idx 0..3.
REQ-018 small_bin SHALL equal snapshot[4*digit_idx+3 : 4*digit_idx], combinational from registers, zero latency.
REQ-019 Snapshot (16 bits) SHALL load the new/continuing owner's data at every frame boundary that ends in an OWN state; inputs mid-frame do not affect the display (no tearing).
REQ-020 IDLE transitions: req0 only -> OWN0; req1 only -> OWN1; both -> requester not served last (last_served pointer), pointer then updated.
REQ-021 OWNx with reqx=0 at boundary -> OWNy if reqy=1, else IDLE.
REQ-022 OWNx with reqx=1, reqy=0 -> stay OWNx indefinitely.
REQ-023 OWNx with reqx=1, reqy=1 -> stay until dwell count reaches DWELL_FRAMES, then switch to OWNy at that boundary.
REQ-024 Dwell counter SHALL clear on every grant change and on entry from IDLE, increment by 1 per owned frame boundary, saturate at DWELL_FRAMES.
REQ-025 frame_done SHALL be 1 for exactly the clk following each owned frame boundary edge, else 0.
REQ-026 blank SHALL be 1 in IDLE; when owned and LZ_BLANK=1, blank=1 for digit k>0 if snapshot nibbles k..3 are all zero; digit 0 never blanked when owned.
REQ-027 Requests dropped and reasserted within one frame SHALL be invisible; only levels sampled at the boundary count.

Reset
REQ-028 Reset=1 at a clk edge SHALL force: state IDLE, gnt=00, AN=1111, digit_idx=0, snapshot=0, small_bin=0, blank=1, frame_done=0, dwell=0, last_served=1 (requester 0 wins first tie).
REQ-029 Reset SHALL take priority over scan_tick and requests, including mid-frame and mid-dwell.

Verification
REQ-030 Reset, req0=1 data0=16'h1234, ticks -> boundary: gnt=01, then AN 1110/1101/1011/0111 with small_bin 4/3/2/1, frame_done pulse after 4th tick.
REQ-031 IDLE, req0=req1=1 same cycle after reset -> gnt=01; DWELL_FRAMES=4 -> gnt=10 exactly at 4th owned boundary, then back to 01 after 4 more.
REQ-032 Owned by 0, data0 changes 16'h00AB->16'h00CD at digit_idx=1 -> digits keep AB until next boundary; digits 2,3 blank=1 (LZ_BLANK=1).
REQ-033 OWN0, req0 dropped mid-frame, req1=0 -> IDLE at boundary, AN=1111, gnt=00, blank=1; req1=1 later -> OWN1 on next tick.
REQ-034 Reset asserted during OWN1 at digit_idx=2 -> next edge all outputs at REQ-028 values, no frame_done pulse.
REQ-035 data0=16'h0000 owned -> digit 0 shows 0 with blank=0, digits 1-3 blank=1; LZ_BLANK=0 -> all blank=0.
